mbus_arbiter: RTL and testbench
===============================

// Module: mbus_arbiter
// PURPOSE
//  Memory-bus arbiter directly downstream of the DMA controller's mbus_* master port.
//  Merges NMASTERS bus masters (CPU load/store unit, DMA controller, ...) onto one memory port.
//  Round-robin grant; one transaction in flight; read data and completion routed back to the requester.
//  Bus-timeout watchdog so a dead slave cannot hang a master.
// PARAMETERS
//  NMASTERS   2     number of master ports (2..8)
//  ADDR_W     48    physical address width
//  DATA_W     64    data width
//  TIMEOUT    255   cycles to wait for mem_ack before aborting (1..65535)
// PORTS
//  clk        in   1              system clock
//  rst        in   1              asynchronous, active-high reset
//  m_re       in   NMASTERS       per-master read request (level, held until m_done)
//  m_we       in   NMASTERS       per-master write request (level, held until m_done)
//  m_addr     in   NMASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata    in   NMASTERS*DATA_W  per-master write data, same packing
//  m_done     out  NMASTERS       one-cycle completion pulse to granted master
//  m_err      out  1              valid with m_done: 1 = timeout or protocol error
//  m_rdata    out  DATA_W         read data, valid with m_done on a successful read
//  m_gnt      out  NMASTERS       one-hot current owner (0 when idle)
//  mem_re     out  1              memory read strobe
//  mem_we     out  1              memory write strobe
//  mem_addr   out  ADDR_W         memory address
//  mem_wdata  out  DATA_W         memory write data
//  mem_rdata  in   DATA_W         memory read data, sampled when mem_ack=1
//  mem_ack    in   1              slave completion; ignored unless mem_re|mem_we
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE; ERR path IDLE -> DONE.
//  IDLE: requesters = m_re|m_we. Pick first requester at or after rr_ptr (wrap NMASTERS-1 -> 0).
//   Winner with re&we both set: protocol error -> DONE with m_err=1, no memory access.
//   Otherwise latch addr/wdata/dir of winner, set m_gnt, go BUSY; no requester -> stay IDLE.
//  BUSY: mem_re/mem_we/mem_addr/mem_wdata driven from latched copy (stable whole phase).
//   Master changes to m_addr/m_wdata/m_re/m_we are ignored until completion.
//   mem_ack=1: capture mem_rdata (reads; writes leave m_rdata unchanged), drop strobes -> DONE.
//   Counter increments each BUSY cycle; reaching TIMEOUT without ack -> drop strobes, m_err=1 -> DONE.
//   mem_ack in the same cycle the counter hits TIMEOUT: ack wins, m_err=0.
//  DONE: m_done[owner]=1 for exactly one cycle with m_err/m_rdata; rr_ptr=(owner+1) mod NMASTERS;
//   m_gnt cleared; counter cleared -> IDLE.
//  Latency: request visible in IDLE cycle N -> strobes high from N+1; ack in cycle M -> m_done in M+1.
//   Zero-wait slave (ack in the first BUSY cycle): 3 cycles request-to-done, 1 idle bubble between grants.
//  Masters drop request on the edge that samples m_done. Arbitration in the following IDLE cycle therefore
//   sees it low, so there is no double issue.
//  mem_ack outside BUSY is ignored. At most one of mem_re/mem_we is ever high.
//  Fairness: with all masters requesting continuously, grants rotate 0,1,..,N-1,0.
// STRUCTURE
//  Package osmx_mbus_pkg: ADDR_W/DATA_W defaults, arb_state_t enum {IDLE,BUSY,DONE}, mbus_dir_t {RD,WR}.
//  Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs one-hot grant and index + any flag.
//  Top holds FSM, latched request, timeout counter, output registers.
// TESTING
//  1 Single read, M0 addr 0x1000140, slave acks first BUSY cycle with 0xDEADBEEF -> m_done[0] at cycle 3, m_rdata=0xDEADBEEF, m_err=0.
//  2 M0 and M1 request writes every cycle for 8 transactions -> grants alternate 0,1,0,1; every write seen exactly once on mem_*.
//  3 Slave never acks, TIMEOUT=4 -> strobes drop after 4 BUSY cycles; m_done[owner]=1 with m_err=1; next master is granted.
//  4 M1 raises re and we together -> m_done[1] with m_err=1; mem_re/mem_we never asserted.
//  5 M0 changes m_addr mid-BUSY -> mem_addr holds the originally latched value until ack.
//  6 Assert rst during BUSY with mem_we=1 -> mem_we, m_gnt, m_done go 0 with no clock edge; after release the first grant goes to M0.

Source files
------------

// File: rtl/osmx_mbus_pkg.sv
// Shared types and default widths for the memory-bus arbiter.
package osmx_mbus_pkg;

    localparam int MBUS_ADDR_W = 48;
    localparam int MBUS_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mbus_dir_t;

endpackage

// File: rtl/mbus_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr, else lowest overall.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] upper;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    always_comb begin
        // NOTE: every variable gets a default before any conditional path, so no latch is inferred.
        upper = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = (i >= int'(ptr));
        end
        masked = req & upper;
        pool   = (|masked) ? masked : req;
        // isolate the lowest set bit of the candidate pool
        gnt    = pool & (~pool + N'(1));
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) idx = IDX_W'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/mbus_arbiter.sv
// Round-robin memory-bus arbiter: one transaction in flight, completion routed back to the owner,
// and a watchdog that aborts a transaction the slave never acknowledges.
module mbus_arbiter
    import osmx_mbus_pkg::*;
#(
    parameter int          NMASTERS = 2,
    parameter int          ADDR_W   = MBUS_ADDR_W,
    parameter int          DATA_W   = MBUS_DATA_W,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NMASTERS-1:0]          m_re,
    input  logic [NMASTERS-1:0]          m_we,
    input  logic [NMASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NMASTERS*DATA_W-1:0]   m_wdata,
    output logic [NMASTERS-1:0]          m_done,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NMASTERS-1:0]          m_gnt,
    output logic                         mem_re,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack
);

    localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    mbus_dir_t           lat_dir;
    logic [15:0]         cnt;

    logic [NMASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_re;
    logic                sel_we;
    logic [IDX_W-1:0]    next_ptr;

    rr_pick #(
        .N     (NMASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (m_re | m_we),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
        sel_re   = m_re[pick_idx];
        sel_we   = m_we[pick_idx];
        next_ptr = (owner == IDX_W'(NMASTERS - 1)) ? '0 : owner + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_dir   <= RD;
            cnt       <= '0;
            m_done    <= '0;
            m_err     <= 1'b0;
            m_rdata   <= '0;
            m_gnt     <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        m_gnt <= pick_gnt;
                        if (sel_re && sel_we) begin
                            // ambiguous direction: complete with an error, never touch memory
                            m_err  <= 1'b1;
                            m_done <= pick_gnt;
                            state  <= S_DONE;
                        end else begin
                            lat_dir   <= sel_we ? WR : RD;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_re    <= sel_re;
                            mem_we    <= sel_we;
                            cnt       <= '0;
                            state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        if (lat_dir == RD) m_rdata <= mem_rdata;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        m_err  <= 1'b0;
                        m_done <= m_gnt;
                        state  <= S_DONE;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        m_err  <= 1'b1;
                        m_done <= m_gnt;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    m_done <= '0;
                    m_err  <= 1'b0;
                    m_gnt  <= '0;
                    cnt    <= '0;
                    rr_ptr <= next_ptr;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_arbiter.sv
// Self-checking bench for mbus_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model (round-robin search, expected completion status and read data).
module tb_mbus_arbiter;

    localparam int N  = 3;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_re;
    logic [N-1:0]    m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_done;
    logic            m_err;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_gnt;
    logic            mem_re;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    int n_cmp = 0;
    int n_err = 0;
    int round_no = 0;
    int exp_ptr;
    logic [DW-1:0] exp_rdata;

    always #5 clk = ~clk;

    mbus_arbiter #(
        .NMASTERS (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_re      (m_re),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .m_gnt     (m_gnt),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (round %0d): observed 0x%0h required 0x%0h", tag, round_no, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'({$urandom, $urandom});
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // first requester found walking forward from the pointer, wrapping around
    function automatic int model_pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_master(input int i, input logic re, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_re[i]              = re;
        m_we[i]              = we;
        m_addr[i*AW +: AW]   = a;
        m_wdata[i*DW +: DW]  = d;
    endtask

    // Called at a negedge while the arbiter is idle; returns at the negedge of the next idle cycle.
    // ack_at: BUSY cycle index in which the slave acks (outside 0..TO-1 means never).
    task automatic round(input logic [N-1:0] re, input logic [N-1:0] we, input int ack_at,
                         input logic [DW-1:0] ack_data, input logic [AW-1:0] fix_addr);
        int            w;
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          is_rd;
        logic          ok;
        round_no++;
        for (int i = 0; i < N; i++) begin
            set_master(i, re[i], we[i],
                       (fix_addr != '0) ? fix_addr + AW'(i * 'h100) : rnd_addr(), rnd_data());
        end
        w = model_pick(re | we);
        if (w < 0) begin
            @(negedge clk);
            check("idle.gnt", 64'(m_gnt), 64'(0));
            check("idle.strobes", 64'({mem_re, mem_we}), 64'(0));
            return;
        end
        oh    = N'(1) << w;
        a     = m_addr[w*AW +: AW];
        d     = m_wdata[w*DW +: DW];
        is_rd = re[w];
        ok    = 1'b0;
        @(negedge clk);
        if (re[w] && we[w]) begin
            check("perr.done", 64'(m_done), 64'(oh));
            check("perr.err", 64'(m_err), 64'(1));
            check("perr.strobes", 64'({mem_re, mem_we}), 64'(0));
            check("perr.gnt", 64'(m_gnt), 64'(oh));
        end else begin
            for (int k = 0; k < TO; k++) begin
                check("busy.re", 64'(mem_re), 64'(is_rd));
                check("busy.we", 64'(mem_we), 64'(!is_rd));
                check("busy.addr", 64'(mem_addr), 64'(a));
                check("busy.wdata", 64'(mem_wdata), 64'(d));
                check("busy.gnt", 64'(m_gnt), 64'(oh));
                check("busy.done", 64'(m_done), 64'(0));
                // the owner changes its request fields mid-transaction; they must be ignored
                set_master(w, re[w], we[w], rnd_addr(), rnd_data());
                if (k == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                    ok        = 1'b1;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = rnd_data();
                end
                @(negedge clk);
                mem_ack = 1'b0;
                if (k == ack_at) break;
            end
            if (ok && is_rd) exp_rdata = ack_data;
            check("done.vec", 64'(m_done), 64'(oh));
            check("done.err", 64'(m_err), 64'(!ok));
            check("done.rdata", 64'(m_rdata), 64'(exp_rdata));
            check("done.strobes", 64'({mem_re, mem_we}), 64'(0));
        end
        exp_ptr = (w + 1) % N;
        // owner drops its request on the edge that samples m_done; a stray ack must be ignored
        set_master(w, 1'b0, 1'b0, rnd_addr(), rnd_data());
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ack = 1'b0;
        check("post.done", 64'(m_done), 64'(0));
        check("post.gnt", 64'(m_gnt), 64'(0));
        check("post.err", 64'(m_err), 64'(0));
        check("post.strobes", 64'({mem_re, mem_we}), 64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        m_re      = '0;
        m_we      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        exp_ptr   = 0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst.outs", 64'({m_done, m_err, m_gnt, mem_re, mem_we}), 64'(0));
        check("rst.addr", 64'(mem_addr), 64'(0));
        check("rst.rdata", 64'(m_rdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // single zero-wait read from M0
        round(3'b001, 3'b000, 0, 64'hDEAD_BEEF, 48'h100_0140);

        // two masters writing back to back: grants alternate, each write issued once
        for (int t = 0; t < 8; t++) begin
            round(3'b000, 3'b011, int'($urandom_range(0, TO - 2)), rnd_data(), '0);
        end

        // dead slave: timeout, then the next master wins
        round(3'b000, 3'b011, -1, rnd_data(), '0);
        round(3'b000, 3'b011, -1, rnd_data(), '0);

        // ack in the last allowed BUSY cycle wins over the timeout
        round(3'b111, 3'b000, TO - 1, rnd_data(), '0);

        // protocol error from M1 alone
        round(3'b010, 3'b010, 0, rnd_data(), '0);

        // slow read whose owner keeps moving its address
        round(3'b001, 3'b000, 2, rnd_data(), '0);

        // all masters requesting: strict rotation
        for (int t = 0; t < 6; t++) begin
            round(3'b101, 3'b010, int'($urandom_range(0, TO - 1)), rnd_data(), '0);
        end

        // random mixes, including idle rounds, protocol errors and timeouts
        for (int t = 0; t < 30; t++) begin
            round(N'($urandom_range(0, 7)), N'($urandom_range(0, 7)),
                  int'($urandom_range(0, TO + 1)) - 1, rnd_data(), '0);
        end

        // asynchronous reset in the middle of a write owned by M1
        round(3'b000, 3'b001, 0, rnd_data(), '0);
        set_master(0, 1'b0, 1'b0, rnd_addr(), rnd_data());
        set_master(1, 1'b0, 1'b1, rnd_addr(), rnd_data());
        set_master(2, 1'b0, 1'b0, rnd_addr(), rnd_data());
        @(negedge clk);
        check("arst.pre_we", 64'(mem_we), 64'(1));
        check("arst.pre_gnt", 64'(m_gnt), 64'(3'b010));
        rst = 1'b1;
        #1;
        check("arst.we", 64'(mem_we), 64'(0));
        check("arst.gnt", 64'(m_gnt), 64'(0));
        check("arst.done", 64'(m_done), 64'(0));
        check("arst.rdata", 64'(m_rdata), 64'(0));
        m_re = '0;
        m_we = '0;
        @(negedge clk);
        rst       = 1'b0;
        exp_ptr   = 0;
        exp_rdata = '0;
        @(negedge clk);
        round(3'b000, 3'b111, 1, rnd_data(), '0);
        round(3'b000, 3'b111, 0, rnd_data(), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1);
    end

endmodule
